// File: rtl/timer_event_logger.sv
// timer_event_logger: timestamps rising edges of the interval timer's irq
// and queues the stamps in a small FIFO that software drains over a 16-bit
// Avalon-MM slave.
//
// Bus handshake: a write is accepted in any cycle where chipselect=1 and
// write_n=0, with no wait states. readdata is registered every clock from
// the current address, whatever chipselect is. It shows the state as it was
// before any write made in that same cycle, and it is valid one cycle after
// the address is presented.
module timer_event_logger #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        event_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0]         CNT_ONE = 1;
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);

  logic [31:0]           timestamp;
  logic [31:0]           snap;
  logic                  prev;
  logic                  en;
  logic                  irq_en;
  logic                  ovf;
  logic [15:0]           drop_cnt;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic [31:0]           mem [DEPTH];

  logic        wr_any, wr_status, wr_ctrl, wr_pop, wr_snap;
  logic        empty, full;
  logic        edge_det, push_req, pop_req, push_ok, clr, drop;
  logic [31:0] head;
  logic [4:0]  count_ext;
  logic [15:0] rd_mux;

  // Bus decode and FIFO control decisions for this cycle.
  always_comb begin
    wr_any    = chipselect & ~write_n;
    wr_status = wr_any & (address == 3'd0);
    wr_ctrl   = wr_any & (address == 3'd1);
    wr_pop    = wr_any & (address == 3'd4);
    wr_snap   = wr_any & ((address == 3'd5) | (address == 3'd6));
    empty     = (count == '0);
    full      = (count == CNT_FULL);
    edge_det  = event_in & ~prev;
    push_req  = edge_det & en;
    pop_req   = wr_pop & ~empty;
    clr       = wr_ctrl & writedata[2];
    // A full FIFO still takes the push when the head leaves in the same cycle.
    push_ok   = push_req & (~full | pop_req);
    // A push swallowed by a clear is not an overflow.
    drop      = push_req & ~push_ok & ~clr;
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else begin
      case ({push_ok, pop_req})
        2'b10:   count_nxt = count + CNT_ONE;
        2'b01:   count_nxt = count - CNT_ONE;
        default: count_nxt = count;
      endcase
    end
  end

  // Free-running cycle counter used as the stamp source.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timestamp <= '0;
    else          timestamp <= timestamp + 32'd1;
  end

  // Previous event level; tracks even while disabled so a standing level is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= 1'b0;
    else          prev <= event_in;
  end

  // Control register: enable and interrupt enable; bit 2 is a clear strobe only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en     <= 1'b0;
      irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      en     <= writedata[0];
      irq_en <= writedata[1];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_req) rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Stamp storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr] <= timestamp;
  end

  // Sticky overflow flag and saturating drop counter; a STATUS write wins over a drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (wr_status) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Software snapshot of the running counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     snap <= '0;
    else if (wr_snap) snap <= timestamp;
  end

  // Interrupt follows the occupancy the FIFO is about to have.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= irq_en & (count_nxt != '0);
  end

  // Read mux over the register map, using pre-write state.
  always_comb begin
    head      = empty ? 32'd0 : mem[rd_ptr];
    count_ext = 5'(count);
    rd_mux    = 16'd0;
    case (address)
      3'd0:    rd_mux = {4'b0, count_ext[3:0], 4'b0, 1'b0, ovf, full, empty};
      3'd1:    rd_mux = {14'b0, irq_en, en};
      3'd2:    rd_mux = head[15:0];
      3'd3:    rd_mux = head[31:16];
      3'd4:    rd_mux = drop_cnt;
      3'd5:    rd_mux = snap[15:0];
      3'd6:    rd_mux = snap[31:16];
      default: rd_mux = 16'd0;
    endcase
  end

  // Registered read data, one-cycle latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule
